// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: owns PC, fills the IR toward decode, handles redirect and HALT
module instruction_fetch_unit #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned PROG_DEPTH  = 128,
   parameter logic [3:0]  HALT_OPCODE = 4'b1111,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        programSelectIn,
   output logic [ADDR_W-1:0] address,
   output logic [1:0]        programSelect,
   input  logic [15:0]       instruction,
   output logic [15:0]       irInstruction,
   output logic [ADDR_W-1:0] irPc,
   output logic              irValid,
   input  logic              decodeReady,
   input  logic              branchValid,
   input  logic [ADDR_W-1:0] branchTarget,
   output logic              running,
   output logic              halted,
   output logic [CNT_W-1:0]  fetchCount
);

   typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx;
   logic [1:0]        sel_nx;
   logic [15:0]       ir_nx;
   logic [ADDR_W-1:0] ir_pc_nx;
   logic              ir_valid_nx;
   logic [CNT_W-1:0]  count_nx;
   logic              transfer;
   logic              slot_free;

   assign transfer  = irValid && decodeReady;
   assign slot_free = !irValid || decodeReady;
   assign address   = pc;
   assign running   = (state == FETCH);
   assign halted    = (state == HALTED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         pc            <= '0;
         programSelect <= '0;
         irInstruction <= '0;
         irPc          <= '0;
         irValid       <= 1'b0;
         fetchCount    <= '0;
      end else begin
         state         <= state_nx;
         pc            <= pc_nx;
         programSelect <= sel_nx;
         irInstruction <= ir_nx;
         irPc          <= ir_pc_nx;
         irValid       <= ir_valid_nx;
         fetchCount    <= count_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      sel_nx      = programSelect;
      ir_nx       = irInstruction;
      ir_pc_nx    = irPc;
      ir_valid_nx = irValid;
      count_nx    = fetchCount;

      // Counting is independent of whatever else the stage does this cycle.
      if (transfer && (fetchCount != '1))
         count_nx = fetchCount + 1'b1;

      if (start) begin
         state_nx    = FETCH;
         pc_nx       = '0;
         sel_nx      = programSelectIn;
         ir_valid_nx = 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (branchValid) begin
                  pc_nx       = ADDR_W'(32'(branchTarget) % 32'(PROG_DEPTH));
                  ir_valid_nx = 1'b0;
               end else if (slot_free) begin
                  ir_nx       = instruction;
                  ir_pc_nx    = pc;
                  ir_valid_nx = 1'b1;
                  if (instruction[15:12] == HALT_OPCODE)
                     state_nx = HALTED;
                  else
                     pc_nx = (pc == LAST_PC) ? '0 : pc + 1'b1;
               end
            end
            HALTED: begin
               if (transfer)
                  ir_valid_nx = 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit with a behavioural model
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  programSelectIn = 2'd0;
   logic [7:0]  address;
   logic [1:0]  programSelect;
   logic [15:0] instruction;
   logic [15:0] irInstruction;
   logic [7:0]  irPc;
   logic        irValid;
   logic        decodeReady = 1'b0;
   logic        branchValid = 1'b0;
   logic [7:0]  branchTarget = 8'd0;
   logic        running;
   logic        halted;
   logic [15:0] fetchCount;

   int checks = 0;
   int failures = 0;

   logic [15:0] mem [4][128];

   // Reference model state: mode 0 idle, 1 running, 2 halted.
   logic [7:0]  m_pc, m_irpc;
   logic [1:0]  m_sel;
   logic [15:0] m_ir, m_count;
   logic        m_valid;
   int          m_mode;

   logic [52:0] dut_vec, exp_vec;

   instruction_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .programSelectIn(programSelectIn),
      .address(address), .programSelect(programSelect), .instruction(instruction),
      .irInstruction(irInstruction), .irPc(irPc), .irValid(irValid),
      .decodeReady(decodeReady), .branchValid(branchValid), .branchTarget(branchTarget),
      .running(running), .halted(halted), .fetchCount(fetchCount)
   );

   always #5 clk = ~clk;

   assign instruction = mem[programSelect][address[6:0]];
   assign dut_vec = {address, programSelect, irInstruction, irPc, irValid, running, halted, fetchCount};
   assign exp_vec = {m_pc, m_sel, m_ir, m_irpc, m_valid, m_mode == 1, m_mode == 2, m_count};

   task automatic model_reset();
      m_pc = 0; m_irpc = 0; m_sel = 0; m_ir = 0; m_count = 0; m_valid = 0; m_mode = 0;
   endtask

   // Advance one clock: model computes the post-edge state from the spec's rules.
   task automatic tick();
      logic [7:0]  n_pc, n_irpc;
      logic [1:0]  n_sel;
      logic [15:0] n_ir, n_count, word;
      logic        n_valid;
      int          n_mode;
      n_pc = m_pc; n_irpc = m_irpc; n_sel = m_sel; n_ir = m_ir;
      n_valid = m_valid; n_mode = m_mode; n_count = m_count;
      if (m_valid && decodeReady && m_count != 16'hFFFF) n_count = m_count + 16'd1;
      if (start) begin
         n_sel = programSelectIn; n_pc = 0; n_valid = 0; n_mode = 1;
      end else if (m_mode == 1) begin
         if (branchValid) begin
            n_pc = 8'(int'(branchTarget) % 128); n_valid = 0;
         end else if (!m_valid || decodeReady) begin
            word = mem[m_sel][m_pc[6:0]];
            n_ir = word; n_irpc = m_pc; n_valid = 1;
            if (word[15:12] == 4'hF) n_mode = 2;
            else n_pc = 8'((int'(m_pc) + 1) % 128);
         end
      end else if (m_mode == 2) begin
         if (m_valid && decodeReady) n_valid = 0;
      end
      @(posedge clk);
      m_pc = n_pc; m_irpc = n_irpc; m_sel = n_sel; m_ir = n_ir;
      m_valid = n_valid; m_mode = n_mode; m_count = n_count;
      #1;
   endtask

   task automatic do_start(input logic [1:0] sel);
      programSelectIn = sel; start = 1'b1;
      tick();
      start = 1'b0; programSelectIn = $urandom_range(0, 3);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut_vec !== 53'd0) begin
         failures++; $display("FAIL reset_values got=%h exp=0", dut_vec);
      end
      rst_n = 1'b1;
      branchValid = 1'b1; decodeReady = 1'b1; branchTarget = 8'h33;
      repeat (3) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++; $display("FAIL idle_hold got=%h exp=%h", dut_vec, exp_vec);
         end
      end
      checks++;
      if (address !== 8'd0 || running !== 1'b0) begin
         failures++; $display("FAIL idle_no_fetch address=%0d running=%b exp 0 0", address, running);
      end
      branchValid = 1'b0;
   endtask

   task automatic test_sequence();
      decodeReady = 1'b1;
      do_start(2'd2);
      checks++;
      if (programSelect !== 2'd2 || address !== 8'd0 || irValid !== 1'b0 || running !== 1'b1) begin
         failures++;
         $display("FAIL start_state sel=%0d addr=%0d valid=%b run=%b exp 2 0 0 1", programSelect, address, irValid, running);
      end
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if (address !== 8'(i) || irPc !== 8'(i - 1) || irValid !== 1'b1 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL sequence i=%0d addr=%0d irPc=%0d valid=%b exp addr=%0d irPc=%0d valid=1 vec=%h exp=%h",
                     i, address, irPc, irValid, i, i - 1, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] cnt0;
      logic        found = 1'b0;
      decodeReady = 1'b1;
      do_start(2'd0);
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (m_valid && m_irpc == 8'd4) found = 1'b1;
      end
      checks++;
      if (!found || irPc !== 8'd4) begin
         failures++; $display("FAIL stall_reach irPc=%0d exp=4", irPc);
      end
      decodeReady = 1'b0;
      cnt0 = fetchCount;
      tick();
      cnt0 = fetchCount;
      repeat (3) begin
         tick();
         checks++;
         if (irPc !== 8'd4 || address !== 8'd5 || fetchCount !== cnt0 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL stall_hold irPc=%0d addr=%0d cnt=%0d exp irPc=4 addr=5 cnt=%0d", irPc, address, fetchCount, cnt0);
         end
      end
      decodeReady = 1'b1;
      tick();
      checks++;
      if (irPc !== 8'd5 || fetchCount !== cnt0 + 16'd1 || dut_vec !== exp_vec) begin
         failures++; $display("FAIL stall_resume irPc=%0d cnt=%0d exp irPc=5 cnt=%0d", irPc, fetchCount, cnt0 + 16'd1);
      end
   endtask

   task automatic test_branch();
      logic found = 1'b0;
      decodeReady = 1'b1;
      do_start(2'd0);
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (m_valid && m_irpc == 8'd6) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++; $display("FAIL branch_reach irPc=%0d exp=6", irPc);
      end
      branchValid = 1'b1; branchTarget = 8'h20;
      tick();
      branchValid = 1'b0;
      checks++;
      if (irValid !== 1'b0 || address !== 8'h20 || dut_vec !== exp_vec) begin
         failures++; $display("FAIL branch_flush valid=%b addr=%h exp valid=0 addr=20 vec=%h exp=%h", irValid, address, dut_vec, exp_vec);
      end
      tick();
      checks++;
      if (irPc !== 8'h20 || irValid !== 1'b1 || dut_vec !== exp_vec) begin
         failures++; $display("FAIL branch_target irPc=%h valid=%b exp irPc=20 valid=1", irPc, irValid);
      end
   endtask

   task automatic test_halt();
      logic [15:0] cnt0;
      decodeReady = 1'b0;
      do_start(2'd1);
      for (int i = 0; i < 8; i++) begin
         decodeReady = (i != 2);
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++; $display("FAIL halt_run i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
         end
      end
      checks++;
      if (halted !== 1'b1 || running !== 1'b0 || address !== 8'd3 || irValid !== 1'b0 || irInstruction !== 16'hF000) begin
         failures++;
         $display("FAIL halt_state halted=%b addr=%0d valid=%b ir=%h exp 1 3 0 F000", halted, address, irValid, irInstruction);
      end
      cnt0 = fetchCount;
      branchValid = 1'b1; branchTarget = 8'h10;
      tick();
      branchValid = 1'b0;
      checks++;
      if (address !== 8'd3 || halted !== 1'b1 || fetchCount !== cnt0) begin
         failures++; $display("FAIL halt_ignore_branch addr=%0d halted=%b exp 3 1", address, halted);
      end
      do_start(2'd1);
      checks++;
      if (running !== 1'b1 || address !== 8'd0 || halted !== 1'b0) begin
         failures++; $display("FAIL halt_restart run=%b addr=%0d exp 1 0", running, address);
      end
   endtask

   task automatic test_wrap();
      decodeReady = 1'b1;
      do_start(2'd2);
      for (int i = 0; i < 127; i++) tick();
      checks++;
      if (address !== 8'd127 || dut_vec !== exp_vec) begin
         failures++; $display("FAIL wrap_end addr=%0d exp=127", address);
      end
      tick();
      checks++;
      if (address !== 8'd0 || irPc !== 8'd127 || dut_vec !== exp_vec) begin
         failures++; $display("FAIL wrap_zero addr=%0d irPc=%0d exp 0 127", address, irPc);
      end
      branchValid = 1'b1; branchTarget = 8'hC5;
      tick();
      branchValid = 1'b0;
      checks++;
      if (address !== 8'h45 || dut_vec !== exp_vec) begin
         failures++; $display("FAIL branch_mod addr=%h exp=45", address);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         decodeReady     = ($urandom_range(0, 3) != 0);
         branchValid     = ($urandom_range(0, 9) == 0);
         branchTarget    = 8'($urandom_range(0, 255));
         start           = ($urandom_range(0, 39) == 0);
         programSelectIn = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if (dut_vec !== exp_vec) begin
            failures++;
            if (errs < 10) $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            errs++;
         end
      end
      start = 1'b0; branchValid = 1'b0;
   endtask

   task automatic test_async_reset();
      decodeReady = 1'b0;
      do_start(2'd0);
      tick();
      checks++;
      if (irValid !== 1'b1 || fetchCount === 16'd0) begin
         failures++; $display("FAIL areset_setup valid=%b cnt=%0d exp valid=1 cnt>0", irValid, fetchCount);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_vec !== 53'd0) begin
         failures++; $display("FAIL areset_async got=%h exp=0", dut_vec);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      decodeReady = 1'b1;
      repeat (3) begin
         tick();
         checks++;
         if (dut_vec !== 53'd0 || exp_vec !== dut_vec) begin
            failures++; $display("FAIL areset_idle got=%h exp=0", dut_vec);
         end
      end
   endtask

   initial begin
      for (int p = 0; p < 4; p++)
         for (int a = 0; a < 128; a++) begin
            mem[p][a] = 16'($urandom);
            if (p != 3 || $urandom_range(0, 15) != 0)
               mem[p][a][15:12] = 4'($urandom_range(0, 14));
         end
      mem[1][3] = 16'hF000;
      model_reset();
      test_reset();
      test_sequence();
      test_stall();
      test_branch();
      test_halt();
      test_wrap();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
